dffsr_bank_ctrl: RTL
====================

Name: dffsr_bank_ctrl

Overview:
- Sequences a shared bank of WIDTH set/clear flip-flops (per-bit CLK, SET, CLR, D, Q cells) on behalf of two requesters.
- Arbitrates commands round-robin and drives per-bit SET/CLR pulses of programmable width, or a synchronous load.
- After each command it reads the bank back, checks the result and returns a response.
- Sits between the control-plane requesters and the flip-flop bank; the bank is clocked by the same CLK.

Parameters:
- WIDTH, 8, number of flip-flops in the bank.
- PULSE_CYC, 2, cycles each SET/CLR pulse is held asserted (legal range 1..255).

Ports:
- CLK  input  1  system clock; bank and controller share it; all logic is rising-edge.
- CLR_N  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a command.
- req0_cmd  input  2  00 READ, 01 SET, 10 CLR, 11 LOAD.
- req0_data  input  WIDTH  bit mask for SET/CLR; load value for LOAD; ignored for READ.
- req0_ready  output  1  command accepted this cycle.
- req1_valid, req1_cmd, req1_data, req1_ready  same widths and meaning, requester 1.
- bank_set  output  WIDTH  per-bit set, active-high, to the bank.
- bank_clr  output  WIDTH  per-bit clear, active-high, to the bank.
- bank_d  output  WIDTH  data to the bank D inputs.
- bank_en  output  1  bank load enable; the bank captures bank_d on the CLK edge where bank_en=1.
- bank_q  input  WIDTH  bank Q outputs.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_id  output  1  requester index of the response.
- rsp_data  output  WIDTH  bank_q snapshot.
- rsp_err  output  1  verify mismatch.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (CLR_N=0, asynchronous):
  - FSM goes to IDLE.
  - bank_set, bank_clr, bank_d, bank_en, rsp_valid, rsp_id, rsp_data, rsp_err, busy all go to 0.
  - Round-robin pointer is set so req0 wins the first tie.
  - An in-flight command is dropped with no response.
  - Bank outputs drop in the same instant (asynchronous), not at the next edge.
- FSM states: IDLE, PULSE, LOAD, SETTLE, RESP.
- IDLE:
  - If any reqN_valid=1, grant one requester. reqN_ready is combinational, =1 only in IDLE for the granted requester.
  - Accept happens on that CLK edge; cmd, data and id are registered.
  - On accept, the round-robin pointer moves so the other requester has priority on the next tie.
  - A lone valid requester is always granted regardless of the pointer.
- Accepted command routing:
  - SET or CLR with a nonzero mask -> PULSE.
  - SET or CLR with a zero mask -> SETTLE (no pulse).
  - LOAD -> LOAD.
  - READ -> SETTLE.
- PULSE:
  - bank_set=mask (SET) or bank_clr=mask (CLR) for exactly PULSE_CYC cycles.
  - bank_set and bank_clr are never nonzero in the same cycle.
  - Counter 8 bits; exits to SETTLE when the counter reaches PULSE_CYC-1.
- LOAD: bank_d=data and bank_en=1 for exactly 1 cycle -> SETTLE.
- SETTLE: all bank outputs 0 (bank_d returns to 0); 1 cycle -> RESP.
- RESP:
  - rsp_valid=1 for exactly 1 cycle; rsp_id=registered id; rsp_data=bank_q sampled this cycle.
  - rsp_err values:
    - SET: 1 if (bank_q & mask)!=mask.
    - CLR: 1 if (bank_q & mask)!=0.
    - LOAD: 1 if bank_q!=data.
    - READ: always 0.
  - RESP -> IDLE.
  - rsp_id, rsp_data and rsp_err hold their values until the next RESP.
- Latency, with accept at edge 0:
  - SET/CLR: pulse in cycles 1..PULSE_CYC; rsp_valid in cycle PULSE_CYC+2.
  - LOAD: rsp_valid in cycle 3.
  - READ: rsp_valid in cycle 2.
  - The next accept is possible in the cycle after RESP.
- Requests arriving while busy are not accepted; reqN_ready stays 0. Requesters must hold valid, cmd and data stable until ready.
- busy=1 in every state except IDLE.

Test Plan:
- Reset then single op: reset, then req0 SET mask 8'hA5, PULSE_CYC=2 -> bank_set=8'hA5 for exactly 2 cycles; rsp_valid at cycle 4; rsp_data=8'hA5; rsp_err=0; rsp_id=0.
- Arbitration tie: req0 and req1 both valid with CLR 8'hFF and LOAD 8'h3C back-to-back.
  - req0 granted first: bank_clr=8'hFF for 2 cycles, then rsp_data=8'h00.
  - req1 granted next: bank_en=1 for one cycle with bank_d=8'h3C, then rsp_data=8'h3C.
  - Next tie goes to req0.
- Verify error: bench forces bank_q bit 0 stuck at 0, then LOAD 8'h01 -> rsp_err=1, rsp_data=8'h00.
- Zero mask and READ:
  - SET mask 0 -> no bank_set activity; rsp_valid at cycle 2; rsp_err=0.
  - READ -> rsp_data=current bank_q at cycle 2.
- Reset mid-pulse: assert CLR_N=0 in the first PULSE cycle of a SET 8'hFF -> bank_set=0 immediately; no rsp_valid; busy=0; after release, the first tie is granted to req0.
- Busy hold-off: req1 raises valid during req0's PULSE -> req1_ready stays 0 until the cycle after req0's RESP, then req1 is accepted.

Source files
------------

// File: rtl/dffsr_bank_ctrl.sv
// Round-robin controller for a shared bank of set/clear flip-flops: pulses SET/CLR
// masks or loads the bank, reads it back, verifies it and returns a response.
module dffsr_bank_ctrl #(
    parameter int WIDTH     = 8,
    parameter int PULSE_CYC = 2
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             req0_valid,
    input  logic [1:0]       req0_cmd,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_cmd,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic [WIDTH-1:0] bank_set,
    output logic [WIDTH-1:0] bank_clr,
    output logic [WIDTH-1:0] bank_d,
    output logic             bank_en,
    input  logic [WIDTH-1:0] bank_q,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, PULSE, LOAD, SETTLE, RESP} state_t;
    typedef enum logic [1:0] {CMD_READ = 2'b00, CMD_SET = 2'b01, CMD_CLR = 2'b10, CMD_LOAD = 2'b11} cmd_t;

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);

    state_t           state, state_nx;
    cmd_t             cmd_r;
    logic [WIDTH-1:0] data_r;
    logic             id_r;
    logic             rr_ptr;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_id_r;
    logic             rsp_err_r;

    logic             grant;
    logic             accept;
    cmd_t             acc_cmd;
    logic [WIDTH-1:0] acc_data;
    logic             err_now;

    // rr_ptr names the requester that wins a tie; a lone requester always wins.
    assign grant      = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    assign accept     = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign acc_cmd    = cmd_t'(grant ? req1_cmd : req0_cmd);
    assign acc_data   = grant ? req1_data : req0_data;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        err_now = 1'b0;
        case (cmd_r)
            CMD_SET:  err_now = (bank_q & data_r) != data_r;
            CMD_CLR:  err_now = (bank_q & data_r) != '0;
            CMD_LOAD: err_now = bank_q != data_r;
            default:  err_now = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (acc_cmd == CMD_LOAD)
                        state_nx = LOAD;
                    else if ((acc_cmd == CMD_SET || acc_cmd == CMD_CLR) && acc_data != '0)
                        state_nx = PULSE;
                    else
                        state_nx = SETTLE;
                end
            end
            PULSE:   if (cnt == PULSE_LAST) state_nx = SETTLE;
            LOAD:    state_nx = SETTLE;
            SETTLE:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bank drive decodes straight from state, so an async reset clears it at once.
    always_comb begin
        bank_set = '0;
        bank_clr = '0;
        bank_d   = '0;
        bank_en  = 1'b0;
        if (state == PULSE) begin
            if (cmd_r == CMD_SET) bank_set = data_r;
            if (cmd_r == CMD_CLR) bank_clr = data_r;
        end
        if (state == LOAD) begin
            bank_d  = data_r;
            bank_en = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state      <= IDLE;
            cmd_r      <= CMD_READ;
            data_r     <= '0;
            id_r       <= 1'b0;
            rr_ptr     <= 1'b0;
            cnt        <= '0;
            rsp_data_r <= '0;
            rsp_id_r   <= 1'b0;
            rsp_err_r  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= state_nx;
            if (accept) begin
                cmd_r  <= acc_cmd;
                data_r <= acc_data;
                id_r   <= grant;
                rr_ptr <= ~grant;
            end
            cnt <= (state == PULSE) ? cnt + 8'd1 : 8'd0;
            if (state == RESP) begin
                rsp_data_r <= bank_q;
                rsp_id_r   <= id_r;
                rsp_err_r  <= err_now;
            end
        end
    end

    // The response reflects bank_q live during RESP and holds that snapshot afterwards.
    assign rsp_valid = (state == RESP);
    assign rsp_id    = rsp_valid ? id_r   : rsp_id_r;
    assign rsp_data  = rsp_valid ? bank_q : rsp_data_r;
    assign rsp_err   = rsp_valid ? err_now : rsp_err_r;
    assign busy      = (state != IDLE);

endmodule
